palm_scan_controller: RTL
=========================

PALM_SCAN_CONTROLLER -- requirements
Module: palm_scan_controller

Interface
REQ-001 Parameters SHALL be:
- IMAGE_WIDTH, default 384: pixels per row.
- IMAGE_HEIGHT, default 216: rows per frame.
- CLR_CYCLES, default 2: cycles for which dp_rst is held in CLEAR.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  arm one capture; sampled only in IDLE.
- pix_valid  in  1  incoming pixel qualifier.
- pix_obj  in  1  binary object pixel.
- pix_sof  in  1  marks the first pixel of a frame; qualified by pix_valid.
- dp_rst  out  1  reset to the palm-measurement datapath.
- dp_obj  out  1  pixel to the datapath.
- dp_flag  out  1  datapath hold; 1 freezes measurement.
- dp_palm_width  in  9  datapath palm width.
- dp_finger_width  in  9  datapath finger width.
- dp_start_c  in  9  datapath palm start column.
- dp_end_c  in  9  datapath palm end column.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_palm_width, res_finger_width, res_start_c, res_end_c  out  9 each  captured results.
- row, col  out  9 each  position of the last accepted pixel.
- busy  out  1  state is not IDLE.
- frame_err  out  1  sticky framing error.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, CLEAR, WAIT_SOF, SCAN, SETTLE, REPORT.
REQ-004 In IDLE, start=1 SHALL move the FSM to CLEAR on the next edge; start SHALL be ignored in every other state.
REQ-005 CLEAR SHALL last exactly CLR_CYCLES cycles with dp_rst=1, then move to WAIT_SOF.
REQ-006 dp_rst SHALL be 1 in IDLE and CLEAR, and 0 in all other states.
REQ-007 In WAIT_SOF, pixels SHALL be ignored (dp_flag=1) until pix_valid&&pix_sof; that pixel SHALL be accepted as row=0, col=0 and the FSM SHALL enter SCAN.
REQ-008 Each accepted pixel SHALL be registered onto dp_obj with dp_flag=0 on the following cycle (latency 1).
REQ-009 A cycle with no accepted pixel SHALL drive dp_flag=1 and dp_obj=0 on the following cycle.
REQ-010 Pixel counting in SCAN:
- col SHALL increment per accepted pixel and wrap from IMAGE_WIDTH-1 to 0.
- row SHALL increment on each wrap.
REQ-011 Acceptance of the pixel at row=IMAGE_HEIGHT-1, col=IMAGE_WIDTH-1 SHALL move the FSM to SETTLE.
REQ-012 SETTLE SHALL last 2 cycles with dp_flag=1. On its second cycle, the four dp_* results SHALL be latched into res_*, and the FSM SHALL enter REPORT with res_valid=1.
REQ-013 In REPORT, res_valid and res_* SHALL hold stable until res_valid&&res_ready. On that handshake, res_valid SHALL fall on the next edge and the FSM SHALL go to IDLE.
REQ-014 pix_valid&&pix_sof in SCAN SHALL:
- set frame_err, and
- return the FSM to CLEAR, which discards the partial frame.
REQ-015 pix_valid data arriving in SETTLE or REPORT SHALL be dropped and SHALL NOT change row or col.
REQ-016 frame_err SHALL clear only on rst or on start accepted in IDLE.
REQ-017 row and col SHALL be 9-bit unsigned. Parameters exceeding 511 are unsupported.

Reset
REQ-018 With rst=1 at an edge, the block SHALL set:
- state=IDLE
- dp_rst=1, dp_flag=1, dp_obj=0
- res_valid=0, all res_*=0
- row=0, col=0
- busy=0, frame_err=0
REQ-019 rst SHALL override any state, including mid-SCAN and mid-handshake. No result SHALL be emitted for an interrupted frame.

Configuration
REQ-020 With macro PALM_SCAN_CONTINUOUS_EN defined, the REPORT handshake SHALL go to CLEAR instead of IDLE, so frames are captured back-to-back with no further start. Without the macro, each capture SHALL require a start pulse.

Verification
REQ-021 The bench SHALL cover these directed scenarios; S1–S5 use IMAGE_WIDTH=8, IMAGE_HEIGHT=4, CLR_CYCLES=2:
- S1: Reset, start, then a 32-pixel contiguous frame with the datapath model returning palm width 5 -> dp_rst high 2 cycles after start; res_valid rises 2 cycles after the last pixel with res_palm_width=5; busy=0 after the handshake.
- S2: pix_valid toggled every other cycle across a frame -> dp_flag=1 in each gap; col=7 then 0 with a row increment; capture occurs only after pixel 32.
- S3: res_ready held low 10 cycles in REPORT -> res_valid and res_* stable throughout; a single handshake on ready.
- S4: pix_sof at row 1, col 3 -> frame_err=1, FSM re-enters CLEAR, no res_valid; the next clean frame reports normally with frame_err still 1 until the next start.
- S5: rst asserted mid-SCAN at row 2 -> all REQ-018 values on the next cycle; start is then required.
- S6: Build with PALM_SCAN_CONTINUOUS_EN -> after the handshake the FSM enters CLEAR without start; two consecutive frames yield two results.

Source files
------------

// File: rtl/palm_scan_controller.sv
// Frame-capture sequencer for the palm-measurement datapath: resets it, streams one frame of pixels, and hands back its results.
// Define PALM_SCAN_CONTINUOUS_EN to re-arm automatically after each result handshake.
module palm_scan_controller #(
    parameter int unsigned IMAGE_WIDTH  = 384,
    parameter int unsigned IMAGE_HEIGHT = 216,
    parameter int unsigned CLR_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pix_valid,
    input  logic       pix_obj,
    input  logic       pix_sof,
    output logic       dp_rst,
    output logic       dp_obj,
    output logic       dp_flag,
    input  logic [8:0] dp_palm_width,
    input  logic [8:0] dp_finger_width,
    input  logic [8:0] dp_start_c,
    input  logic [8:0] dp_end_c,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [8:0] res_palm_width,
    output logic [8:0] res_finger_width,
    output logic [8:0] res_start_c,
    output logic [8:0] res_end_c,
    output logic [8:0] row,
    output logic [8:0] col,
    output logic       busy,
    output logic       frame_err
);

    localparam int unsigned POS_W = 9;
    localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [POS_W-1:0] COL_LAST = POS_W'(IMAGE_WIDTH - 1);
    localparam logic [POS_W-1:0] ROW_LAST = POS_W'(IMAGE_HEIGHT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_SOF,
        SCAN,
        SETTLE,
        REPORT
    } state_t;

    state_t             state, state_n;
    logic [CLR_W-1:0]   clr_cnt, clr_cnt_n;
    logic               settle_cnt, settle_cnt_n;
    logic [POS_W-1:0]   row_n, col_n, row_adv, col_adv;
    logic               dp_rst_n, dp_obj_n, dp_flag_n, busy_n;
    logic               res_valid_n, frame_err_n;
    logic [8:0]         res_palm_width_n, res_finger_width_n, res_start_c_n, res_end_c_n;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            clr_cnt          <= '0;
            settle_cnt       <= 1'b0;
            row              <= '0;
            col              <= '0;
            dp_rst           <= 1'b1;
            dp_obj           <= 1'b0;
            dp_flag          <= 1'b1;
            busy             <= 1'b0;
            res_valid        <= 1'b0;
            frame_err        <= 1'b0;
            res_palm_width   <= '0;
            res_finger_width <= '0;
            res_start_c      <= '0;
            res_end_c        <= '0;
        end else begin
            state            <= state_n;
            clr_cnt          <= clr_cnt_n;
            settle_cnt       <= settle_cnt_n;
            row              <= row_n;
            col              <= col_n;
            dp_rst           <= dp_rst_n;
            dp_obj           <= dp_obj_n;
            dp_flag          <= dp_flag_n;
            busy             <= busy_n;
            res_valid        <= res_valid_n;
            frame_err        <= frame_err_n;
            res_palm_width   <= res_palm_width_n;
            res_finger_width <= res_finger_width_n;
            res_start_c      <= res_start_c_n;
            res_end_c        <= res_end_c_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n            = state;
        clr_cnt_n          = clr_cnt;
        settle_cnt_n       = settle_cnt;
        row_n              = row;
        col_n              = col;
        dp_obj_n           = 1'b0;
        dp_flag_n          = 1'b1;
        res_valid_n        = res_valid;
        frame_err_n        = frame_err;
        res_palm_width_n   = res_palm_width;
        res_finger_width_n = res_finger_width;
        res_start_c_n      = res_start_c;
        res_end_c_n        = res_end_c;

        col_adv = (col == COL_LAST) ? '0 : col + POS_W'(1);
        row_adv = (col == COL_LAST) ? row + POS_W'(1) : row;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = CLEAR;
                    clr_cnt_n   = '0;
                    frame_err_n = 1'b0;
                end
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_n = WAIT_SOF;
                end else begin
                    clr_cnt_n = clr_cnt + CLR_W'(1);
                end
            end
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    row_n     = '0;
                    col_n     = '0;
                    dp_obj_n  = pix_obj;
                    dp_flag_n = 1'b0;
                    state_n   = SCAN;
                end
            end
            SCAN: begin
                if (pix_valid && pix_sof) begin
                    // Unexpected frame start: abandon the partial frame
                    frame_err_n = 1'b1;
                    state_n     = CLEAR;
                    clr_cnt_n   = '0;
                end else if (pix_valid) begin
                    row_n     = row_adv;
                    col_n     = col_adv;
                    dp_obj_n  = pix_obj;
                    dp_flag_n = 1'b0;
                    if (row_adv == ROW_LAST && col_adv == COL_LAST) begin
                        state_n      = SETTLE;
                        settle_cnt_n = 1'b0;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt) begin
                    res_palm_width_n   = dp_palm_width;
                    res_finger_width_n = dp_finger_width;
                    res_start_c_n      = dp_start_c;
                    res_end_c_n        = dp_end_c;
                    res_valid_n        = 1'b1;
                    state_n            = REPORT;
                end else begin
                    settle_cnt_n = 1'b1;
                end
            end
            REPORT: begin
                if (res_valid && res_ready) begin
                    res_valid_n = 1'b0;
`ifdef PALM_SCAN_CONTINUOUS_EN
                    state_n     = CLEAR;
                    clr_cnt_n   = '0;
`else
                    state_n     = IDLE;
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        dp_rst_n = (state_n == IDLE) || (state_n == CLEAR);
        busy_n   = (state_n != IDLE);
    end

endmodule
